// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory-ready
// handshake, illegal-opcode and memory-timeout traps, and a retired-instruction counter.
// Define JUMP_EN to decode opcode 000010 as an unconditional jump instead of trapping it.
module multicycle_ctrl_fsm #(
  parameter int OP_W     = 6,
  parameter int ALUOP_W  = 3,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic [1:0]         pc_src_o,
  output logic               i_or_d_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               illegal_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   retired_o
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);
`ifdef JUMP_EN
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
`endif

  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_LW  = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_SW  = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_BEQ = ALUOP_W'(3'b101);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t              state_r;
  state_t              stateNext_s;
  logic [OP_W-1:0]     opQ_r;
  logic [WAIT_W-1:0]   waitCnt_r;
  logic [WAIT_W-1:0]   waitCntNext_s;
  logic                illegal_r;
  logic                timeout_r;
  logic [CNT_W-1:0]    retired_r;
  logic                illegalHit_s;
  logic                timeoutHit_s;
  logic                retireHit_s;

  // State register, latched opcode, stall counter, sticky traps and retire counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= S_IDLE;
      opQ_r     <= '0;
      waitCnt_r <= '0;
      illegal_r <= 1'b0;
      timeout_r <= 1'b0;
      retired_r <= '0;
    end else begin
      state_r   <= stateNext_s;
      waitCnt_r <= waitCntNext_s;
      if (state_r == S_DECODE) begin
        opQ_r <= instr_op_i;
      end
      if (illegalHit_s) begin
        illegal_r <= 1'b1;
      end
      if (timeoutHit_s) begin
        timeout_r <= 1'b1;
      end
      if (retireHit_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end
    end
  end

  // Next-state, trap detection and stall counting
  always_comb begin
    stateNext_s   = state_r;
    waitCntNext_s = WAIT_W'(0);
    illegalHit_s  = 1'b0;
    timeoutHit_s  = 1'b0;
    retireHit_s   = 1'b0;
    case (state_r)
      S_IDLE: stateNext_s = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        // A ready on the limit cycle still completes the access.
        if (mem_ready_i) begin
          if (state_r == S_FETCH) begin
            stateNext_s = S_DECODE;
          end else if (state_r == S_MEM_RD) begin
            stateNext_s = S_MEM_WB;
          end else begin
            stateNext_s = S_FETCH;
            retireHit_s = 1'b1;
          end
        end else if (waitCnt_r == WAIT_LIM) begin
          stateNext_s  = S_TRAP;
          timeoutHit_s = 1'b1;
        end else begin
          waitCntNext_s = waitCnt_r + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        case (instr_op_i)
          OP_R:           stateNext_s = S_EXEC_R;
          OP_LW, OP_SW:   stateNext_s = S_MEM_ADDR;
          OP_BEQ:         stateNext_s = S_BRANCH;
          OP_ADDI, OP_SLTI: stateNext_s = S_EXEC_I;
`ifdef JUMP_EN
          OP_J:           stateNext_s = S_JUMP;
`endif
          default: begin
            stateNext_s  = S_TRAP;
            illegalHit_s = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        if (opQ_r == OP_LW) begin
          stateNext_s = S_MEM_RD;
        end else begin
          stateNext_s = S_MEM_WR;
        end
      end
      S_EXEC_R: stateNext_s = S_R_WB;
      S_EXEC_I: stateNext_s = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
        stateNext_s = S_FETCH;
        retireHit_s = 1'b1;
      end
      S_TRAP: stateNext_s = S_TRAP;
      default: stateNext_s = S_IDLE;
    endcase
  end

  // Moore output decode; FETCH gates the IR/PC load on the ready handshake
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 2'b00;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = ALU_R;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = ALU_ADD;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        alu_op_o    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        if (opQ_r == OP_LW) begin
          alu_op_o = ALU_LW;
        end else begin
          alu_op_o = ALU_SW;
        end
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      S_EXEC_R: alu_src_a_o = 1'b1;
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        if (opQ_r == OP_SLTI) begin
          alu_op_o = ALU_SLT;
        end else begin
          alu_op_o = ALU_ADD;
        end
      end
      S_I_WB: reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_BEQ;
        pc_write_cond_o = 1'b1;
        pc_src_o        = 2'b01;
      end
`ifdef JUMP_EN
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
      end
`endif
      default: pc_write_o = 1'b0;
    endcase
  end

  assign illegal_o = illegal_r;
  assign timeout_o = timeout_r;
  assign retired_o = retired_r;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: a vector table walked cycle by cycle plus
// hand-built stall/timeout/reset sequences, checked through an expected-value queue.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  instrOp;
  logic        memReady;
  logic        pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite, aluSrcA;
  logic        regWrite, regDst, memToReg, illegal, timeout;
  logic [1:0]  pcSrc, aluSrcB;
  logic [2:0]  aluOp;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(instrOp), .mem_ready_i(memReady),
    .pc_write_o(pcWrite), .pc_write_cond_o(pcWriteCond), .pc_src_o(pcSrc),
    .i_or_d_o(iOrD), .mem_read_o(memRead), .mem_write_o(memWrite), .ir_write_o(irWrite),
    .alu_src_a_o(aluSrcA), .alu_src_b_o(aluSrcB), .alu_op_o(aluOp),
    .reg_write_o(regWrite), .reg_dst_o(regDst), .mem_to_reg_o(memToReg),
    .illegal_o(illegal), .timeout_o(timeout), .retired_o(retired)
  );

  // Field order: pcW pcWC pcSrc iOrD mR mW irW srcA srcB aluOp regW regDst m2r ill to
  localparam logic [18:0] C_IDLE      = 19'd0;
  localparam logic [18:0] C_FETCH_RDY = {1'b1,1'b0,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,2'b01,3'b001,3'b000,2'b00};
  localparam logic [18:0] C_FETCH_WT  = {1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,2'b01,3'b001,3'b000,2'b00};
  localparam logic [18:0] C_DECODE    = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b001,3'b000,2'b00};
  localparam logic [18:0] C_MADDR_LW  = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b011,3'b000,2'b00};
  localparam logic [18:0] C_MADDR_SW  = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b100,3'b000,2'b00};
  localparam logic [18:0] C_MEMRD     = {1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b00};
  localparam logic [18:0] C_MEMWB     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b101,2'b00};
  localparam logic [18:0] C_MEMWR     = {1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,3'b000,2'b00};
  localparam logic [18:0] C_EXECR     = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,3'b000,2'b00};
  localparam logic [18:0] C_RWB       = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b110,2'b00};
  localparam logic [18:0] C_EXECI_ADD = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b001,3'b000,2'b00};
  localparam logic [18:0] C_EXECI_SLT = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b010,3'b000,2'b00};
  localparam logic [18:0] C_IWB       = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b100,2'b00};
  localparam logic [18:0] C_BRANCH    = {1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b101,3'b000,2'b00};
`ifdef JUMP_EN
  localparam logic [18:0] C_JUMP      = {1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b00};
`endif
  localparam logic [18:0] F_ILL       = 19'b10;
  localparam logic [18:0] F_TO        = 19'b01;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;

  typedef struct {
    string       name;
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [18:0] ctl;
    logic [31:0] ret;
  } vec_t;

  typedef struct {
    string       name;
    logic [18:0] ctl;
    logic [31:0] ret;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   nTests = 0;
  int   nFail  = 0;

  function automatic void add(input string name, input logic r, input logic [5:0] op,
                              input logic rdy, input logic [18:0] ctl, input logic [31:0] ret);
    vecs.push_back('{name, r, op, rdy, ctl, ret});
  endfunction

  task automatic checkOut();
    exp_t        e;
    logic [18:0] act;
    e   = sb.pop_front();
    act = {pcWrite, pcWriteCond, pcSrc, iOrD, memRead, memWrite, irWrite, aluSrcA, aluSrcB,
           aluOp, regWrite, regDst, memToReg, illegal, timeout};
    nTests++;
    if (act !== e.ctl || retired !== e.ret) begin
      nFail++;
      $display("FAIL %s: ctl=%b retired=%0d, expected ctl=%b retired=%0d",
               e.name, act, retired, e.ctl, e.ret);
    end
  endtask

  task automatic applyVec(input vec_t v);
    @(posedge clk);
    #1;
    rst      = v.rst;
    instrOp  = v.op;
    memReady = v.rdy;
    sb.push_back('{v.name, v.ctl, v.ret});
    @(negedge clk);
    checkOut();
  endtask

  task automatic step(input string name, input logic r, input logic [5:0] op, input logic rdy,
                      input logic [18:0] ctl, input logic [31:0] ret);
    vec_t v;
    v = '{name, r, op, rdy, ctl, ret};
    applyVec(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instrOp = OP_R; memReady = 1'b1;
    // Each row: inputs driven this cycle and the outputs expected in the same cycle.
    add("reset",      1'b1, OP_R,    1'b1, C_IDLE,      32'd0);
    add("idle",       1'b0, OP_R,    1'b1, C_IDLE,      32'd0);
    add("r_fetch",    1'b0, OP_R,    1'b1, C_FETCH_RDY, 32'd0);
    add("r_decode",   1'b0, OP_R,    1'b1, C_DECODE,    32'd0);
    add("r_exec",     1'b0, OP_R,    1'b1, C_EXECR,     32'd0);
    add("r_wb",       1'b0, OP_R,    1'b1, C_RWB,       32'd0);
    add("addi_fetch", 1'b0, OP_R,    1'b1, C_FETCH_RDY, 32'd1);
    add("addi_dec",   1'b0, OP_ADDI, 1'b1, C_DECODE,    32'd1);
    add("addi_exec",  1'b0, OP_R,    1'b1, C_EXECI_ADD, 32'd1);
    add("addi_wb",    1'b0, OP_R,    1'b1, C_IWB,       32'd1);
    add("slti_fetch", 1'b0, OP_R,    1'b1, C_FETCH_RDY, 32'd2);
    add("slti_dec",   1'b0, OP_SLTI, 1'b1, C_DECODE,    32'd2);
    add("slti_exec",  1'b0, OP_R,    1'b1, C_EXECI_SLT, 32'd2);
    add("slti_wb",    1'b0, OP_R,    1'b1, C_IWB,       32'd2);
    add("lw_fetch",   1'b0, OP_R,    1'b1, C_FETCH_RDY, 32'd3);
    add("lw_dec",     1'b0, OP_LW,   1'b1, C_DECODE,    32'd3);
    add("lw_addr",    1'b0, OP_R,    1'b1, C_MADDR_LW,  32'd3);
    add("lw_stall1",  1'b0, OP_R,    1'b0, C_MEMRD,     32'd3);
    add("lw_stall2",  1'b0, OP_R,    1'b0, C_MEMRD,     32'd3);
    add("lw_stall3",  1'b0, OP_R,    1'b0, C_MEMRD,     32'd3);
    add("lw_rd_rdy",  1'b0, OP_R,    1'b1, C_MEMRD,     32'd3);
    add("lw_wb",      1'b0, OP_R,    1'b1, C_MEMWB,     32'd3);
    add("beq_fetch",  1'b0, OP_R,    1'b1, C_FETCH_RDY, 32'd4);
    add("beq_dec",    1'b0, OP_BEQ,  1'b1, C_DECODE,    32'd4);
    add("beq_exec",   1'b0, OP_R,    1'b1, C_BRANCH,    32'd4);
    add("sw_fetch",   1'b0, OP_R,    1'b1, C_FETCH_RDY, 32'd5);
    add("sw_dec",     1'b0, OP_SW,   1'b1, C_DECODE,    32'd5);
    add("sw_addr",    1'b0, OP_R,    1'b1, C_MADDR_SW,  32'd5);
    add("sw_wr",      1'b0, OP_R,    1'b1, C_MEMWR,     32'd5);
    add("f_wait",     1'b0, OP_R,    1'b0, C_FETCH_WT,  32'd6);
    add("j_fetch",    1'b0, OP_R,    1'b1, C_FETCH_RDY, 32'd6);
    add("j_dec",      1'b0, OP_J,    1'b1, C_DECODE,    32'd6);
`ifdef JUMP_EN
    add("jump",       1'b0, OP_R,    1'b1, C_JUMP,      32'd6);
    add("bad_fetch",  1'b0, OP_R,    1'b1, C_FETCH_RDY, 32'd7);
    add("bad_dec",    1'b0, OP_BAD,  1'b1, C_DECODE,    32'd7);
    add("trap_ill",   1'b0, OP_R,    1'b1, F_ILL,       32'd7);
    add("trap_hold",  1'b0, OP_R,    1'b0, F_ILL,       32'd7);
    add("trap_rst",   1'b1, OP_R,    1'b1, F_ILL,       32'd7);
`else
    add("j_trap_ill", 1'b0, OP_R,    1'b1, F_ILL,       32'd6);
    add("trap_hold",  1'b0, OP_R,    1'b0, F_ILL,       32'd6);
    add("trap_rst",   1'b1, OP_R,    1'b1, F_ILL,       32'd6);
`endif
    add("post_rst",   1'b0, OP_R,    1'b1, C_IDLE,      32'd0);

    repeat (3) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyVec(vecs[i]);
    end

    // Fifteen stalls then ready on the limit cycle: the access completes, no trap.
    for (int i = 0; i < 15; i++) step($sformatf("stall15_%0d", i), 1'b0, OP_R, 1'b0, C_FETCH_WT, 32'd0);
    step("ready_at_limit", 1'b0, OP_R, 1'b1, C_FETCH_RDY, 32'd0);
    step("lim_dec",        1'b0, OP_R, 1'b1, C_DECODE,    32'd0);
    step("lim_exec",       1'b0, OP_R, 1'b1, C_EXECR,     32'd0);
    step("lim_wb",         1'b0, OP_R, 1'b1, C_RWB,       32'd0);

    // Sixteen stalls: the sixteenth enters TRAP with timeout raised.
    for (int i = 0; i < 16; i++) step($sformatf("stall16_%0d", i), 1'b0, OP_R, 1'b0, C_FETCH_WT, 32'd1);
    step("trap_to",      1'b0, OP_R, 1'b1, F_TO,   32'd1);
    step("trap_to_hold", 1'b0, OP_R, 1'b1, F_TO,   32'd1);
    step("trap_to_rst",  1'b1, OP_R, 1'b1, F_TO,   32'd1);
    step("to_cleared",   1'b0, OP_R, 1'b1, C_IDLE, 32'd0);

    // Reset asserted mid-load aborts the access; a store then retires normally.
    step("ab_fetch",  1'b0, OP_R,  1'b1, C_FETCH_RDY, 32'd0);
    step("ab_dec",    1'b0, OP_LW, 1'b1, C_DECODE,    32'd0);
    step("ab_addr",   1'b0, OP_R,  1'b1, C_MADDR_LW,  32'd0);
    step("ab_stall",  1'b0, OP_R,  1'b0, C_MEMRD,     32'd0);
    step("ab_rst",    1'b1, OP_R,  1'b0, C_MEMRD,     32'd0);
    step("ab_idle",   1'b0, OP_R,  1'b1, C_IDLE,      32'd0);
    step("sw2_fetch", 1'b0, OP_R,  1'b1, C_FETCH_RDY, 32'd0);
    step("sw2_dec",   1'b0, OP_SW, 1'b1, C_DECODE,    32'd0);
    step("sw2_addr",  1'b0, OP_R,  1'b1, C_MADDR_SW,  32'd0);
    step("sw2_wait",  1'b0, OP_R,  1'b0, C_MEMWR,     32'd0);
    step("sw2_wr",    1'b0, OP_R,  1'b1, C_MEMWR,     32'd0);
    step("sw2_done",  1'b0, OP_R,  1'b1, C_FETCH_RDY, 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
